// File: rtl/ro_puf_meas_ctrl.sv
// ro_puf_meas_ctrl
// -----------------------------------------------------------------------------
// Measurement sequencer for a four-oscillator, two-bit ring-oscillator PUF.
// A start request latches the challenge and enables the oscillators. The
// oscillators settle for SETTLE_CYC cycles, then their synchronized rising
// edges are counted over a window of WINDOW (or 2*WINDOW) clk cycles. The
// counts are then compared pairwise to form a 2-bit response, which is held
// with resp_valid until the consumer takes it with resp_ready.
//
// Optional feature macro: RO_PUF_MAJORITY_EN
//   When defined, every request runs three SETTLE->COUNT->COMPARE rounds.
//   resp is the bitwise 2-of-3 majority of the round results and resp_tie is
//   the OR of the round tie flags. When undefined, a single round is run.
//
// Ports
//   clk         in   single clock
//   rst_n       in   asynchronous active-low reset
//   start       in   measurement request, only looked at in IDLE
//   challenge   in   [0] pairing select, [1] window select (latched on start)
//   ro_out      in   raw oscillator outputs, asynchronous to clk
//   ro_en       out  oscillator enables
//   busy        out  high from the cycle after start acceptance until IDLE
//   resp        out  response bits
//   resp_tie    out  at least one compared pair had equal counts
//   resp_valid  out  response available (DONE state)
//   resp_ready  in   consumer accepts the response
// -----------------------------------------------------------------------------
module ro_puf_meas_ctrl #(
    parameter int WINDOW     = 64,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] challenge,
    input  logic [3:0] ro_out,
    output logic [3:0] ro_en,
    output logic       busy,
    output logic [1:0] resp,
    output logic       resp_tie,
    output logic       resp_valid,
    input  logic       resp_ready
);

    // Timer must hold the longest window minus one and the settle time minus one.
    localparam int TMR_MAX = (2 * WINDOW > SETTLE_CYC) ? 2 * WINDOW : SETTLE_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WIN1_M1   = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] WIN2_M1   = TMR_W'(2 * WINDOW - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_COUNT   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Bitwise 2-of-3 vote.
    function automatic logic [1:0] maj3(input logic [1:0] a,
                                        input logic [1:0] b,
                                        input logic [1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [1:0]         chal_q, chal_d;
    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         sync3_q, sync3_d;
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];
    logic [3:0]         ro_en_q, ro_en_d;
    logic               busy_q, busy_d;
    logic [1:0]         resp_q, resp_d;
    logic               resp_tie_q, resp_tie_d;
    logic               resp_valid_q, resp_valid_d;

`ifdef RO_PUF_MAJORITY_EN
    logic [1:0]         round_q, round_d;
    logic [1:0]         res0_q, res0_d;
    logic [1:0]         res1_q, res1_d;
    logic               tie_acc_q, tie_acc_d;
`endif

    logic [3:0]         edge_s;
    logic               clr_cnt_s;
    logic [TMR_W-1:0]   win_m1_s;
    logic [CNT_W-1:0]   a_first_s, a_second_s, b_first_s, b_second_s;
    logic [1:0]         cmp_resp_s;
    logic               cmp_tie_s;

    // Rising edge seen by the synchronizer: second stage high, history low.
    assign edge_s = sync2_q & ~sync3_q;

    // Pair selection, window length and the pairwise comparison.
    always_comb begin
        a_first_s  = cnt_q[0];
        b_second_s = cnt_q[3];
        if (chal_q[0]) begin
            a_second_s = cnt_q[2];
            b_first_s  = cnt_q[1];
        end else begin
            a_second_s = cnt_q[1];
            b_first_s  = cnt_q[2];
        end
        if (chal_q[1]) begin
            win_m1_s = WIN2_M1;
        end else begin
            win_m1_s = WIN1_M1;
        end
        // Two saturated counters compare equal, so saturation reads as a tie.
        cmp_resp_s = {(b_first_s > b_second_s), (a_first_s > a_second_s)};
        cmp_tie_s  = (a_first_s == a_second_s) | (b_first_s == b_second_s);
    end

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        chal_d     = chal_q;
        resp_d     = resp_q;
        resp_tie_d = resp_tie_q;
        clr_cnt_s  = 1'b0;
        sync1_d    = ro_out;
        sync2_d    = sync1_q;
        sync3_d    = sync2_q;
`ifdef RO_PUF_MAJORITY_EN
        round_d    = round_q;
        res0_d     = res0_q;
        res1_d     = res1_q;
        tie_acc_d  = tie_acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chal_d    = challenge;
                    tmr_d     = SETTLE_M1;
                    clr_cnt_s = 1'b1;
                    state_d   = ST_SETTLE;
`ifdef RO_PUF_MAJORITY_EN
                    round_d   = 2'd0;
                    tie_acc_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    tmr_d   = win_m1_s;
                    state_d = ST_COUNT;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_COUNT: begin
                if (tmr_q == '0) begin
                    state_d = ST_COMPARE;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            ST_COMPARE: begin
`ifdef RO_PUF_MAJORITY_EN
                if (round_q == 2'd2) begin
                    resp_d     = maj3(res0_q, res1_q, cmp_resp_s);
                    resp_tie_d = tie_acc_q | cmp_tie_s;
                    round_d    = 2'd0;
                    state_d    = ST_DONE;
                end else begin
                    // Park this round's result and start the next round.
                    if (round_q == 2'd0) begin
                        res0_d = cmp_resp_s;
                    end else begin
                        res1_d = cmp_resp_s;
                    end
                    tie_acc_d = tie_acc_q | cmp_tie_s;
                    round_d   = round_q + 2'd1;
                    tmr_d     = SETTLE_M1;
                    clr_cnt_s = 1'b1;
                    state_d   = ST_SETTLE;
                end
`else
                resp_d     = cmp_resp_s;
                resp_tie_d = cmp_tie_s;
                state_d    = ST_DONE;
`endif
            end
            ST_DONE: begin
                // resp_valid is always high here, so ready alone completes it.
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            if (clr_cnt_s) begin
                cnt_d[i] = '0;
            end else if ((state_q == ST_COUNT) && edge_s[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end

        // Outputs are decoded from the next state so they change with it.
        if ((state_d == ST_SETTLE) || (state_d == ST_COUNT)) begin
            ro_en_d = 4'hF;
        end else begin
            ro_en_d = 4'h0;
        end
        busy_d       = (state_d != ST_IDLE);
        resp_valid_d = (state_d == ST_DONE);
    end

    // State, synchronizer, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            chal_q       <= 2'b00;
            sync1_q      <= 4'h0;
            sync2_q      <= 4'h0;
            sync3_q      <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            ro_en_q      <= 4'h0;
            busy_q       <= 1'b0;
            resp_q       <= 2'b00;
            resp_tie_q   <= 1'b0;
            resp_valid_q <= 1'b0;
`ifdef RO_PUF_MAJORITY_EN
            round_q      <= 2'd0;
            res0_q       <= 2'b00;
            res1_q       <= 2'b00;
            tie_acc_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            chal_q       <= chal_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ro_en_q      <= ro_en_d;
            busy_q       <= busy_d;
            resp_q       <= resp_d;
            resp_tie_q   <= resp_tie_d;
            resp_valid_q <= resp_valid_d;
`ifdef RO_PUF_MAJORITY_EN
            round_q      <= round_d;
            res0_q       <= res0_d;
            res1_q       <= res1_d;
            tie_acc_q    <= tie_acc_d;
`endif
        end
    end

    assign ro_en      = ro_en_q;
    assign busy       = busy_q;
    assign resp       = resp_q;
    assign resp_tie   = resp_tie_q;
    assign resp_valid = resp_valid_q;

endmodule
